// File: rtl/digital_tube_scan_bcd_if.sv
// Bus bundle for the multiplexed seven-segment driver:
// load side (value, strobe, dp mask) and display side (status, segments, digits).
interface digital_tube_scan_bcd_if #(
  parameter int DIGITS = 4,
  parameter int DATA_W = 14
);
  logic [DATA_W-1:0] Number_Data;
  logic              Load;
  logic [DIGITS-1:0] DP_Mask;
  logic              Busy;
  logic              Overflow;
  logic [7:0]        Row_Scan_Sig;
  logic [DIGITS-1:0] Column_Scan_Sig;

  modport master (
    output Number_Data, Load, DP_Mask,
    input  Busy, Overflow, Row_Scan_Sig, Column_Scan_Sig
  );

  modport slave (
    input  Number_Data, Load, DP_Mask,
    output Busy, Overflow, Row_Scan_Sig, Column_Scan_Sig
  );
endinterface

// File: rtl/digital_tube_scan_bcd.sv
// N-digit multiplexed seven-segment driver with a sequential
// shift-add-3 binary-to-BCD converter, zero blanking and overflow dashes.
module digital_tube_scan_bcd #(
  parameter int DIGITS         = 4,
  parameter int DATA_W         = 14,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int BLANK_LZ       = 1
) (
  input logic CLK,
  input logic RST,
  digital_tube_scan_bcd_if.slave bus
);

  // ceil(DATA_W * log10(2)) decimal digits, never fewer than displayed
  localparam int BCD_D = (DATA_W * 30103 + 99999) / 100000;
  localparam int NB    = (BCD_D > DIGITS) ? BCD_D : DIGITS;
  localparam int CW    = $clog2(DATA_W);
  localparam int SW    = $clog2(SCAN_DIV);
  localparam int IW    = $clog2(DIGITS);

  localparam logic [7:0] ROW_OFF =
    (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] COL_OFF =
    (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   bin_q, bin_d;
  logic [4*NB-1:0]     bcd_q, bcd_d;
  logic [4*NB-1:0]     adj;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DIGITS-1:0]   dp_pend_q, dp_pend_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic                ovf_q, ovf_d;
  logic [SW-1:0]       scan_q, scan_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [7:0]          row_q, row_d;
  logic [DIGITS-1:0]   col_q, col_d;

  logic [3:0]          nib;
  logic                hi_zero;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   onehot;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    unique case (n)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NB; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    dp_pend_d = dp_pend_q;
    disp_d    = disp_q;
    disp_dp_d = disp_dp_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.Load) begin
          state_d   = S_CONV;
          bin_d     = bus.Number_Data;
          bcd_d     = '0;
          cnt_d     = '0;
          dp_pend_d = bus.DP_Mask;
        end
      end
      S_CONV: begin
        {bcd_d, bin_d} = {adj[4*NB-2:0], bin_q, 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DATA_W - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        disp_d    = bcd_q[4*DIGITS-1:0];
        disp_dp_d = dp_pend_q;
        ovf_d     = 1'b0;
        for (int i = DIGITS; i < NB; i++) begin
          if (bcd_q[4*i +: 4] != 4'd0) ovf_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Digit i blanks only when it and everything above it is zero
  always_comb begin
    nib     = disp_q[4*idx_q +: 4];
    hi_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(idx_q) && disp_q[4*j +: 4] != 4'd0) hi_zero = 1'b0;
    end
    seg = {disp_dp_q[idx_q], seg7(nib)};
    if (BLANK_LZ != 0 && idx_q != '0 && hi_zero) seg[6:0] = 7'h00;
    if (ovf_q) seg = 8'h40;
    onehot = DIGITS'(1) << idx_q;
    row_d  = (SEG_ACTIVE_LOW != 0) ? ~seg : seg;
    col_d  = (DIG_ACTIVE_LOW != 0) ? ~onehot : onehot;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      dp_pend_q <= '0;
      disp_q    <= '0;
      disp_dp_q <= '0;
      ovf_q     <= 1'b0;
      scan_q    <= '0;
      idx_q     <= '0;
      row_q     <= ROW_OFF;
      col_q     <= COL_OFF;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      dp_pend_q <= dp_pend_d;
      disp_q    <= disp_d;
      disp_dp_q <= disp_dp_d;
      ovf_q     <= ovf_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      row_q     <= row_d;
      col_q     <= col_d;
    end
  end

  assign bus.Busy            = (state_q != S_IDLE);
  assign bus.Overflow        = ovf_q;
  assign bus.Row_Scan_Sig    = row_q;
  assign bus.Column_Scan_Sig = col_q;

endmodule
